usi_bus_initiator: RTL and testbench
====================================

# usi_bus_initiator

Bus initiator that drives the manager side of the USI peripheral bus (wen/ren/addr/wdata out; rdata/error/request_stall in). It accepts single read/write commands on a valid/ready command port and returns one response per command on a valid/ready response port. It handles wait states and misaligned addresses, and aborts accesses that stall too long. It sits between a controller or test sequencer and any bus-attached peripheral register map, such as the USI register block at offsets 0x00–0x14.

## Interface
- TIMEOUT, 16: max consecutive stalled cycles before abort; legal range 2..65535.
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  initiator can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  byte address; must be word-aligned.
- cmd_wdata  in  32  write data; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  32  read data; 0 for writes and for errored accesses.
- rsp_error  out  1  access failed (bus error, misalignment or timeout).
- rsp_timeout  out  1  the failure was a timeout.
- bus_wen  out  1  write enable.
- bus_ren  out  1  read enable.
- bus_addr  out  32  address.
- bus_wdata  out  32  write data.
- bus_rdata  in  32  read data, valid in a non-stalled access cycle.
- bus_error  in  1  peripheral error, sampled in the completing cycle.
- bus_request_stall  in  1  peripheral not ready; extends the access.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch write, addr and wdata.
  - If addr[1:0]!=0: go to RESP with rsp_error=1, rsp_timeout=0, rsp_rdata=0. No bus access occurs.
  - Otherwise go to ACCESS and clear the stall counter.
- ACCESS:
  - bus_wen=write and bus_ren=!write, held continuously. bus_addr and bus_wdata are held at the latched values.
  - If bus_request_stall=0, the access completes:
    - rsp_rdata = write ? 0 : (bus_error ? 0 : bus_rdata).
    - rsp_error = bus_error; rsp_timeout = 0.
    - Go to RESP.
  - If bus_request_stall=1 and the counter equals TIMEOUT-1, abort:
    - rsp_error=1, rsp_timeout=1, rsp_rdata=0.
    - Go to RESP.
  - Otherwise increment the counter (16-bit, never wraps) and stay in ACCESS.
- RESP:
  - rsp_valid=1; response fields are stable until taken.
  - On rsp_ready, go to IDLE.
  - cmd_ready=0 in this state, so there is exactly one outstanding command.
- bus_wen and bus_ren are never both 1, and both are 0 outside ACCESS.
- bus_addr and bus_wdata are 0 outside ACCESS. This keeps the peripheral's address decode quiet.

## Timing
- Reset values:
  - state = IDLE.
  - cmd_ready = 1.
  - rsp_valid, rsp_error, rsp_timeout, bus_wen, bus_ren = 0.
  - rsp_rdata, bus_addr, bus_wdata = 0.
  - Stall counter = 0.
- Latency, no stall:
  - Command accepted at edge N.
  - Bus enables asserted during cycle N+1.
  - rsp_valid in cycle N+2.
  - Next command can be accepted in the cycle after the rsp handshake.
- With k stall cycles (k < TIMEOUT), rsp_valid rises at N+2+k.
- Timeout: enables are held for exactly TIMEOUT cycles, then rsp_valid rises on the next cycle.
- Misaligned command: rsp_valid rises at N+1, with no bus cycle.
- rsp_ready held high before rsp_valid: the handshake completes in the first RESP cycle.
- Stall deasserting in the same cycle the counter reaches TIMEOUT-1: normal completion takes priority over abort.
- nRST asserted mid-ACCESS or mid-RESP: all outputs return to reset values immediately (asynchronous). The pending command is dropped with no response.
- All bus outputs are registered, so they are glitch-free.

## Test plan
- Write 0x0000_0003 to 0x0, no stall:
  - bus_wen=1 for 1 cycle with addr 0x0 and wdata 0x3.
  - rsp_valid 2 cycles after accept; rsp_error=0, rsp_rdata=0.
- Read 0x4 with bus_rdata=0x1234_5678 and 3 stall cycles:
  - bus_ren=1 for 4 cycles.
  - rsp_rdata=0x1234_5678, rsp_error=0, rsp_valid at accept+5.
- Read 0x8 with stall held forever, TIMEOUT=16:
  - bus_ren high exactly 16 cycles.
  - rsp_error=1, rsp_timeout=1, rsp_rdata=0.
- Write to 0x6:
  - No bus_wen pulse.
  - Next-cycle response with rsp_error=1, rsp_timeout=0.
- Read 0x14 with bus_error=1 and no stall:
  - rsp_error=1, rsp_rdata=0.
  - Hold rsp_ready=0 for 5 cycles: the response stays stable and cmd_ready stays 0.
- Assert nRST during a stalled ACCESS:
  - All outputs go to reset values at once.
  - After release, a read of 0xC completes normally.

Source files
------------

// File: rtl/usi_bus_initiator.sv
// USI bus manager: one valid/ready command in, one bus access, one valid/ready response out.
// Latency 2 cycles accept-to-response (+1 per stall cycle); no bus cycle for misaligned addresses.
module usi_bus_initiator #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        rsp_timeout,
    output logic        bus_wen,
    output logic        bus_ren,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_error,
    input  logic        bus_request_stall
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT - 1);

    state_t      r_state, w_state;
    logic        r_cmd_ready, w_cmd_ready;
    logic        r_rsp_valid, w_rsp_valid;
    logic [31:0] r_rsp_rdata, w_rsp_rdata;
    logic        r_rsp_error, w_rsp_error;
    logic        r_rsp_timeout, w_rsp_timeout;
    logic        r_bus_wen, w_bus_wen;
    logic        r_bus_ren, w_bus_ren;
    logic [31:0] r_bus_addr, w_bus_addr;
    logic [31:0] r_bus_wdata, w_bus_wdata;
    logic [15:0] r_stall_cnt, w_stall_cnt;

    // Every output comes straight from a register; the next values are computed here.
    always_comb begin
        w_state       = r_state;
        w_cmd_ready   = r_cmd_ready;
        w_rsp_valid   = r_rsp_valid;
        w_rsp_rdata   = r_rsp_rdata;
        w_rsp_error   = r_rsp_error;
        w_rsp_timeout = r_rsp_timeout;
        w_bus_wen     = r_bus_wen;
        w_bus_ren     = r_bus_ren;
        w_bus_addr    = r_bus_addr;
        w_bus_wdata   = r_bus_wdata;
        w_stall_cnt   = r_stall_cnt;
        case (r_state)
            IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    w_cmd_ready = 1'b0;
                    if (cmd_addr[1:0] != 2'b00) begin
                        w_state       = RESP;
                        w_rsp_valid   = 1'b1;
                        w_rsp_error   = 1'b1;
                        w_rsp_timeout = 1'b0;
                        w_rsp_rdata   = 32'h0;
                    end else begin
                        w_state     = ACCESS;
                        w_bus_wen   = cmd_write;
                        w_bus_ren   = !cmd_write;
                        w_bus_addr  = cmd_addr;
                        w_bus_wdata = cmd_wdata;
                        w_stall_cnt = 16'h0;
                    end
                end
            end
            ACCESS: begin
                // Completion wins over abort when stall drops on the last allowed cycle.
                if (!bus_request_stall || (r_stall_cnt == LP_CNT_LAST)) begin
                    w_state       = RESP;
                    w_rsp_valid   = 1'b1;
                    w_bus_wen     = 1'b0;
                    w_bus_ren     = 1'b0;
                    w_bus_addr    = 32'h0;
                    w_bus_wdata   = 32'h0;
                    if (!bus_request_stall) begin
                        w_rsp_error   = bus_error;
                        w_rsp_timeout = 1'b0;
                        w_rsp_rdata   = (r_bus_wen || bus_error) ? 32'h0 : bus_rdata;
                    end else begin
                        w_rsp_error   = 1'b1;
                        w_rsp_timeout = 1'b1;
                        w_rsp_rdata   = 32'h0;
                    end
                end else if (r_stall_cnt != 16'hFFFF) begin
                    w_stall_cnt = r_stall_cnt + 16'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state       = IDLE;
                    w_cmd_ready   = 1'b1;
                    w_rsp_valid   = 1'b0;
                    w_rsp_rdata   = 32'h0;
                    w_rsp_error   = 1'b0;
                    w_rsp_timeout = 1'b0;
                end
            end
            default: begin
                w_state     = IDLE;
                w_cmd_ready = 1'b1;
                w_rsp_valid = 1'b0;
                w_bus_wen   = 1'b0;
                w_bus_ren   = 1'b0;
                w_bus_addr  = 32'h0;
                w_bus_wdata = 32'h0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state       <= IDLE;
            r_cmd_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= 32'h0;
            r_rsp_error   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_bus_wen     <= 1'b0;
            r_bus_ren     <= 1'b0;
            r_bus_addr    <= 32'h0;
            r_bus_wdata   <= 32'h0;
            r_stall_cnt   <= 16'h0;
        end else begin
            r_state       <= w_state;
            r_cmd_ready   <= w_cmd_ready;
            r_rsp_valid   <= w_rsp_valid;
            r_rsp_rdata   <= w_rsp_rdata;
            r_rsp_error   <= w_rsp_error;
            r_rsp_timeout <= w_rsp_timeout;
            r_bus_wen     <= w_bus_wen;
            r_bus_ren     <= w_bus_ren;
            r_bus_addr    <= w_bus_addr;
            r_bus_wdata   <= w_bus_wdata;
            r_stall_cnt   <= w_stall_cnt;
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_error   = r_rsp_error;
    assign rsp_timeout = r_rsp_timeout;
    assign bus_wen     = r_bus_wen;
    assign bus_ren     = r_bus_ren;
    assign bus_addr    = r_bus_addr;
    assign bus_wdata   = r_bus_wdata;

endmodule

// File: tb/tb_usi_bus_initiator.sv
// Directed bench for usi_bus_initiator: vector table plus reset and handshake corner sequences.
module tb_usi_bus_initiator;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'h0;
    logic [31:0] cmd_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        rsp_timeout;
    logic        bus_wen;
    logic        bus_ren;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_error = 1'b0;
    logic        bus_request_stall = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    usi_bus_initiator #(.TIMEOUT(16)) dut (
        .CLK(CLK), .nRST(nRST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
        .bus_wen(bus_wen), .bus_ren(bus_ren), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_error(bus_error), .bus_request_stall(bus_request_stall)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          k;        // stalled access cycles before completion
        logic [31:0] rdata;
        bit          berr;
        int          hold;     // cycles rsp_ready stays low after rsp_valid
        bit          exp_err;
        bit          exp_to;
        logic [31:0] exp_rdata;
        int          exp_lat;  // cycle of rsp_valid counted from the accept edge
        int          exp_en;   // cycles with an enable asserted
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_rsp"}, {29'd0, rsp_valid, rsp_error, rsp_timeout}, 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_bus_en"}, {30'd0, bus_wen, bus_ren}, 32'd0);
        chk({tag, "_bus_addr"}, bus_addr, 32'd0);
        chk({tag, "_bus_wdata"}, bus_wdata, 32'd0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int edges = 0;
        int en = 0;
        int bus_bad = 0;
        int hold_bad = 0;
        bit done = 1'b0;
        string tag = $sformatf("v%0d", idx);
        @(negedge CLK);
        cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata;
        bus_rdata = v.rdata; bus_error = v.berr; bus_request_stall = 1'b0; rsp_ready = 1'b0;
        chk({tag, "_cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
        @(posedge CLK);
        while (!done && edges < 200) begin
            @(negedge CLK);
            edges++;
            cmd_valid = 1'b0;
            if (bus_wen || bus_ren) begin
                en++;
                bus_request_stall = (en <= v.k);
                if (bus_addr !== v.addr || bus_wdata !== v.wdata ||
                    bus_wen !== v.write || bus_ren !== !v.write)
                    bus_bad++;
            end
            if (rsp_valid) done = 1'b1;
        end
        bus_request_stall = 1'b0;
        chk({tag, "_rsp_seen"}, 32'(done), 32'd1);
        chk({tag, "_latency"}, 32'(edges), 32'(v.exp_lat));
        chk({tag, "_en_cycles"}, 32'(en), 32'(v.exp_en));
        chk({tag, "_bus_fields"}, 32'(bus_bad), 32'd0);
        chk({tag, "_rsp_error"}, 32'(rsp_error), 32'(v.exp_err));
        chk({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'(v.exp_to));
        chk({tag, "_rsp_rdata"}, rsp_rdata, v.exp_rdata);
        chk({tag, "_bus_quiet"}, {30'd0, bus_wen, bus_ren} | bus_addr | bus_wdata, 32'd0);
        for (int i = 0; i < v.hold; i++) begin
            @(negedge CLK);
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_error !== v.exp_err ||
                rsp_timeout !== v.exp_to || rsp_rdata !== v.exp_rdata)
                hold_bad++;
        end
        if (v.hold > 0) chk({tag, "_rsp_hold"}, 32'(hold_bad), 32'd0);
        chk({tag, "_cmd_ready_resp"}, 32'(cmd_ready), 32'd0);
        rsp_ready = 1'b1;
        @(negedge CLK);
        rsp_ready = 1'b0;
        chk({tag, "_rsp_done"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_cmd_ready_after"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        //           wr    addr          wdata         k     rdata         berr hold err to exp_rdata     lat en
        vecs[0] = '{1'b1, 32'h0000_0000, 32'h0000_0003, 0,    32'h0,         0, 0, 0, 0, 32'h0,         2,  1};
        vecs[1] = '{1'b0, 32'h0000_0004, 32'h0000_0000, 3,    32'h1234_5678, 0, 0, 0, 0, 32'h1234_5678, 5,  4};
        vecs[2] = '{1'b0, 32'h0000_0008, 32'h0000_0000, 1000, 32'h5555_AAAA, 0, 0, 1, 1, 32'h0,         17, 16};
        vecs[3] = '{1'b1, 32'h0000_0006, 32'h0000_00FF, 0,    32'h0,         0, 0, 1, 0, 32'h0,         1,  0};
        vecs[4] = '{1'b0, 32'h0000_0014, 32'h0000_0000, 0,    32'hDEAD_BEEF, 1, 5, 1, 0, 32'h0,         2,  1};
        vecs[5] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 15,   32'h0000_A5A5, 0, 0, 0, 0, 32'h0000_A5A5, 17, 16};
        vecs[6] = '{1'b1, 32'h0000_0014, 32'h8765_4321, 2,    32'h1111_1111, 1, 0, 1, 0, 32'h0,         4,  3};
        vecs[7] = '{1'b0, 32'h0000_0001, 32'h0000_0000, 0,    32'h2222_2222, 0, 0, 1, 0, 32'h0,         1,  0};
        vecs[8] = '{1'b0, 32'h0000_000C, 32'h0000_0000, 14,   32'h0BAD_F00D, 0, 2, 0, 0, 32'h0BAD_F00D, 16, 15};

        #7;
        chk_reset_outputs("reset");
        @(negedge CLK);
        nRST = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // rsp_ready already high: handshake completes in the first RESP cycle.
        @(negedge CLK);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10; cmd_wdata = 32'h0;
        bus_rdata = 32'hCAFE_0001; bus_error = 1'b0; bus_request_stall = 1'b0; rsp_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        cmd_valid = 1'b0;
        chk("early_ready_ren", 32'(bus_ren), 32'd1);
        @(negedge CLK);
        chk("early_ready_valid", 32'(rsp_valid), 32'd1);
        chk("early_ready_rdata", rsp_rdata, 32'hCAFE_0001);
        @(negedge CLK);
        chk("early_ready_gone", 32'(rsp_valid), 32'd0);
        chk("early_ready_cmd_ready", 32'(cmd_ready), 32'd1);
        rsp_ready = 1'b0;

        // Asynchronous reset during a stalled access drops the command.
        @(negedge CLK);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8; bus_request_stall = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        cmd_valid = 1'b0;
        repeat (3) @(negedge CLK);
        chk("mid_access_ren", 32'(bus_ren), 32'd1);
        chk("mid_access_addr", bus_addr, 32'h8);
        #2;
        nRST = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        @(negedge CLK);
        bus_request_stall = 1'b0;
        nRST = 1'b1;
        repeat (2) @(negedge CLK);
        chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        run_vec(9, '{1'b0, 32'h0000_000C, 32'h0, 0, 32'h0C0C_0C0C, 0, 0, 0, 0, 32'h0C0C_0C0C, 2, 1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
